// File: rtl/iir_stream_checker.sv
// rtl/iir_stream_checker.sv - filter output stream checker against buffered golden samples
module iir_stream_checker #(
    parameter int NB    = 12,
    parameter int DEPTH = 16,
    parameter int NSAMP = 201,
    parameter int TOL   = 0,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN,
    input  logic [NB-1:0] DIN,
    input  logic          EXP_V,
    input  logic [NB-1:0] EXP_D,
    output logic          FULL,
    output logic          EMPTY,
    output logic          MISMATCH,
    output logic [CW-1:0] SAMP_CNT,
    output logic [CW-1:0] ERR_CNT,
    output logic          OVERFLOW,
    output logic          UNDERFLOW,
    output logic          DONE,
    output logic          PASS
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [NB:0]   TOL_C   = (NB+1)'(TOL);
    localparam logic [CW-1:0] NSAMP_C = CW'(NSAMP);
    localparam logic [CW-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;

    logic [NB-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic               active;
    logic               pop;
    logic               push;
    logic               bypass;
    logic               ovf_evt;
    logic               unf_evt;
    logic               cmp;
    logic               cmp_fail;
    logic [NB-1:0]      exp_sel;
    logic signed [NB:0] diff;
    logic [NB:0]        abs_diff;
    logic [CW-1:0]      samp_nx;
    logic [CW-1:0]      err_nx;
    logic               ovf_nx;
    logic               unf_nx;

    assign FULL    = (count == DEPTH_C);
    assign EMPTY   = (count == '0);
    assign active  = (state != S_DONE);
    assign pop     = active && VIN && !EMPTY;
    // An empty FIFO with a golden sample arriving is compared directly, leaving the FIFO untouched
    assign bypass  = active && VIN && EMPTY && EXP_V;
    assign push    = active && EXP_V && !bypass && (!FULL || pop);
    assign ovf_evt = active && EXP_V && FULL && !pop;
    assign unf_evt = active && VIN && EMPTY && !EXP_V;
    assign cmp     = active && VIN;

    assign exp_sel  = EMPTY ? EXP_D : mem[rd_ptr];
    assign diff     = $signed({DIN[NB-1], DIN}) - $signed({exp_sel[NB-1], exp_sel});
    assign abs_diff = diff[NB] ? $unsigned(-diff) : $unsigned(diff);
    assign cmp_fail = unf_evt || (abs_diff > TOL_C);

    assign samp_nx = cmp ? SAMP_CNT + 1'b1 : SAMP_CNT;
    assign err_nx  = (cmp && cmp_fail && (ERR_CNT != ERR_MAX)) ? ERR_CNT + 1'b1 : ERR_CNT;
    assign ovf_nx  = OVERFLOW || ovf_evt;
    assign unf_nx  = UNDERFLOW || unf_evt;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= EXP_D;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            MISMATCH  <= 1'b0;
            SAMP_CNT  <= '0;
            ERR_CNT   <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            MISMATCH <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            case (state)
                S_IDLE, S_RUN: begin
                    SAMP_CNT  <= samp_nx;
                    ERR_CNT   <= err_nx;
                    OVERFLOW  <= ovf_nx;
                    UNDERFLOW <= unf_nx;
                    MISMATCH  <= cmp && cmp_fail;
                    if (cmp && (samp_nx == NSAMP_C)) begin
                        state <= S_DONE;
                        DONE  <= 1'b1;
                        PASS  <= (err_nx == '0) && !ovf_nx && !unf_nx;
                    end else if ((state == S_IDLE) && (VIN || EXP_V)) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iir_stream_checker.sv
// tb/tb_iir_stream_checker.sv - self-checking bench for iir_stream_checker
module tb_iir_stream_checker;
    localparam int NB    = 12;
    localparam int CW    = 16;
    localparam int NSAMP = 201;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          vin;
    logic [NB-1:0] din;
    logic          exp_v;
    logic [NB-1:0] exp_d;

    logic full_a, empty_a, mm_a, ovf_a, unf_a, done_a, pass_a;
    logic full_b, empty_b, mm_b, ovf_b, unf_b, done_b, pass_b;
    logic full_c, empty_c, mm_c, ovf_c, unf_c, done_c, pass_c;
    logic [CW-1:0] samp_a, err_a, samp_b, err_b, samp_c, err_c;

    iir_stream_checker #(.NB(NB), .DEPTH(128), .NSAMP(NSAMP), .TOL(0), .CW(CW)) dut_a (
        .CLK(clk), .RST_n(rst_n), .VIN(vin), .DIN(din), .EXP_V(exp_v), .EXP_D(exp_d),
        .FULL(full_a), .EMPTY(empty_a), .MISMATCH(mm_a), .SAMP_CNT(samp_a), .ERR_CNT(err_a),
        .OVERFLOW(ovf_a), .UNDERFLOW(unf_a), .DONE(done_a), .PASS(pass_a));

    iir_stream_checker #(.NB(NB), .DEPTH(128), .NSAMP(NSAMP), .TOL(1), .CW(CW)) dut_b (
        .CLK(clk), .RST_n(rst_n), .VIN(vin), .DIN(din), .EXP_V(exp_v), .EXP_D(exp_d),
        .FULL(full_b), .EMPTY(empty_b), .MISMATCH(mm_b), .SAMP_CNT(samp_b), .ERR_CNT(err_b),
        .OVERFLOW(ovf_b), .UNDERFLOW(unf_b), .DONE(done_b), .PASS(pass_b));

    iir_stream_checker #(.NB(NB), .DEPTH(16), .NSAMP(NSAMP), .TOL(0), .CW(CW)) dut_c (
        .CLK(clk), .RST_n(rst_n), .VIN(vin), .DIN(din), .EXP_V(exp_v), .EXP_D(exp_d),
        .FULL(full_c), .EMPTY(empty_c), .MISMATCH(mm_c), .SAMP_CNT(samp_c), .ERR_CNT(err_c),
        .OVERFLOW(ovf_c), .UNDERFLOW(unf_c), .DONE(done_c), .PASS(pass_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected MISMATCH per accepted VIN, for the TOL=0 and TOL=1 instances
    typedef struct packed {
        logic mm_a;
        logic mm_b;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;
    logic sb_en = 1'b0;
    logic vin_s = 1'b0;
    int   mm_seen_a = 0;
    int   mm_seen_b = 0;

    always @(posedge clk) vin_s <= vin && sb_en;

    always @(negedge clk) begin
        if (vin_s) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underrun: MISMATCH seen with no expectation queued");
            end else begin
                sb_e = sb_q.pop_front();
                check("mismatch_a", int'(mm_a), int'(sb_e.mm_a));
                check("mismatch_b", int'(mm_b), int'(sb_e.mm_b));
            end
        end else if (sb_en) begin
            check("mismatch_idle_a", int'(mm_a), 0);
        end
        if (sb_en && mm_a) mm_seen_a++;
        if (sb_en && mm_b) mm_seen_b++;
    end

    task automatic do_reset();
        sb_en = 1'b0;
        rst_n = 1'b0;
        vin   = 1'b0;
        exp_v = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Golden k*3 pushed every cycle; VIN starts at cycle 5, skipping every third cycle
    task automatic run_stream(input int e10, input int e50, input int stop_at);
        int   kp;
        int   kv;
        int   cyc;
        int   err;
        exp_t e;
        kp  = 0;
        kv  = 0;
        cyc = 0;
        sb_en = 1'b1;
        while (kv < stop_at && cyc < 2000) begin
            exp_v = (kp < NSAMP);
            exp_d = NB'(kp * 3);
            if (exp_v) kp++;
            if (cyc >= 5 && ((cyc - 5) % 3) != 2) begin
                err    = (kv == 10) ? e10 : ((kv == 50) ? e50 : 0);
                vin    = 1'b1;
                din    = NB'(kv * 3 + err);
                e.mm_a = (err != 0);
                e.mm_b = (err > 1) || (err < -1);
                sb_q.push_back(e);
                kv++;
            end else begin
                vin = 1'b0;
            end
            tick();
            cyc++;
            if (kv == NSAMP - 1 && vin) check("done_before_last", int'(done_a), 0);
        end
        check("stream_vin_count", kv, stop_at);
        vin   = 1'b0;
        exp_v = 1'b0;
    endtask

    typedef struct {
        logic          rst_n;
        logic          vin;
        logic [NB-1:0] din;
        logic          exp_v;
        logic [NB-1:0] exp_d;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
        logic          mm;
        int            samp;
        int            err;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input logic r, input logic v, input int d, input logic ev, input int ed,
                           input logic f, input logic em, input logic ov, input logic un,
                           input logic mm, input int s, input int er);
        vec_t x;
        x.rst_n = r;  x.vin = v;   x.din = NB'(d); x.exp_v = ev; x.exp_d = NB'(ed);
        x.full  = f;  x.empty = em; x.ovf = ov;    x.unf = un;   x.mm = mm;
        x.samp  = s;  x.err = er;
        tbl.push_back(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // FIFO corner table for the DEPTH=16 instance
        add_vec(0, 0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++)
            add_vec(1, 0, 0, 1, 100 + i, (i == 16), 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 1, 117,     1, 0, 1, 0, 0, 0, 0);
        add_vec(1, 1, 101, 1, 200,   1, 0, 1, 0, 0, 1, 0);
        add_vec(1, 1, 999, 0, 0,     0, 0, 1, 0, 1, 2, 1);
        add_vec(0, 0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 1, 5, 0, 0,       0, 1, 0, 1, 1, 1, 1);
        add_vec(0, 0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 1, -2048, 1, -2048, 0, 1, 0, 0, 0, 1, 0);
        add_vec(1, 1, 5, 1, -3,      0, 1, 0, 0, 1, 2, 1);
        add_vec(1, 0, 77, 0, 0,      0, 1, 0, 0, 0, 2, 1);

        rst_n = 1'b0; vin = 1'b0; din = '0; exp_v = 1'b0; exp_d = '0;
        tick();
        tick();
        check("rst_empty", int'(empty_a), 1);
        check("rst_full", int'(full_a), 0);
        check("rst_samp", int'(samp_a), 0);
        check("rst_err", int'(err_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_pass", int'(pass_a), 0);
        check("rst_mm", int'(mm_a), 0);
        rst_n = 1'b1;

        // Clean stream
        run_stream(0, 0, NSAMP);
        check("a_samp", int'(samp_a), NSAMP);
        check("a_err", int'(err_a), 0);
        check("a_done", int'(done_a), 1);
        check("a_pass", int'(pass_a), 1);
        check("a_ovf", int'(ovf_a), 0);
        sb_en = 1'b0;
        vin = 1'b1; din = NB'(7); exp_v = 1'b1; exp_d = NB'(1);
        tick();
        tick();
        vin = 1'b0; exp_v = 1'b0;
        check("hold_samp", int'(samp_a), NSAMP);
        check("hold_err", int'(err_a), 0);
        check("hold_mm", int'(mm_a), 0);
        check("hold_pass", int'(pass_a), 1);

        // Errors at k=10 (+1) and k=50 (-2)
        do_reset();
        mm_seen_a = 0;
        mm_seen_b = 0;
        run_stream(1, -2, NSAMP);
        @(negedge clk);
        #1;
        check("b_mm_pulses_tol0", mm_seen_a, 2);
        check("b_mm_pulses_tol1", mm_seen_b, 1);
        check("b_err_tol0", int'(err_a), 2);
        check("b_done_tol0", int'(done_a), 1);
        check("b_pass_tol0", int'(pass_a), 0);
        check("b_err_tol1", int'(err_b), 1);
        check("b_done_tol1", int'(done_b), 1);
        check("b_pass_tol1", int'(pass_b), 0);

        // Reset after 100 samples, then full replay
        do_reset();
        run_stream(0, 0, 100);
        check("mid_samp", int'(samp_a), 100);
        sb_en = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_samp", int'(samp_a), 0);
        check("mid_rst_err", int'(err_a), 0);
        check("mid_rst_empty", int'(empty_a), 1);
        check("mid_rst_done", int'(done_a), 0);
        check("mid_rst_ovf", int'(ovf_a), 0);
        rst_n = 1'b1;
        run_stream(0, 0, NSAMP);
        check("replay_samp", int'(samp_a), NSAMP);
        check("replay_done", int'(done_a), 1);
        check("replay_pass", int'(pass_a), 1);
        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);

        // FIFO corner table
        do_reset();
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            vin   = tbl[i].vin;
            din   = tbl[i].din;
            exp_v = tbl[i].exp_v;
            exp_d = tbl[i].exp_d;
            tick();
            check($sformatf("vec%0d_full", i), int'(full_c), int'(tbl[i].full));
            check($sformatf("vec%0d_empty", i), int'(empty_c), int'(tbl[i].empty));
            check($sformatf("vec%0d_ovf", i), int'(ovf_c), int'(tbl[i].ovf));
            check($sformatf("vec%0d_unf", i), int'(unf_c), int'(tbl[i].unf));
            check($sformatf("vec%0d_mm", i), int'(mm_c), int'(tbl[i].mm));
            check($sformatf("vec%0d_samp", i), int'(samp_c), tbl[i].samp);
            check($sformatf("vec%0d_err", i), int'(err_c), tbl[i].err);
        end
        check("table_done", int'(done_c), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
